alarm_tone_sequencer: RTL and testbench
=======================================

// Module: alarm_tone_sequencer
// PURPOSE
// Sequences the alarm buzzer. Drives the rate input of the shared programmable square-wave divider
// (5 MHz base, 23-bit rate in Hz) and gates its output. Produces bursts of beeps with alternating pitch.
// Handles the snooze and stop buttons, plus auto-timeout. Sits between alarm-match logic/buttons and the divider.
// PARAMETERS
// MS_CYCLES      5000  clk cycles per 1 ms tick (5 MHz); bench overrides to a small value
// TONE_A_HZ      2000  rate for even-indexed beeps in a burst
// TONE_B_HZ      2500  rate for odd-indexed beeps in a burst
// BEEPS          4     beeps per burst (1..7)
// BEEP_MS        100   beep (tone-on) duration, ms
// GAP_MS         100   silence between beeps within a burst, ms
// PAUSE_MS       600   silence after the last beep of a burst, ms
// SNOOZE_MS      300000 snooze duration, ms (fits 24 bits)
// MAX_BURSTS     60    bursts rung with no button press before auto-stop (1..255)
// MAX_SNOOZES    3     snoozes allowed per alarm event; the next snooze press acts as stop
// PORTS
// clk         in   1   system clock, 5 MHz
// rst         in   1   synchronous, active-high reset
// alarm_en    in   1   alarm armed switch (level)
// alarm_trig  in   1   alarm time match (level); rising edge detected internally
// snooze_btn  in   1   snooze request, one-cycle pulse, debounced upstream
// stop_btn    in   1   stop request, one-cycle pulse, debounced upstream
// rate_out    out  23  rate to the divider: TONE_A_HZ/TONE_B_HZ in TONE, else 23'd1 (never 0)
// tone_en     out  1   1 only in TONE; gates the divider output to the buzzer
// ringing     out  1   1 in TONE, GAP, PAUSE
// snoozing    out  1   1 in SNOOZE
// BEHAVIOUR
// - States: IDLE, TONE, GAP, PAUSE, SNOOZE. All outputs are registered.
// - Reset values: state=IDLE, rate_out=1, tone_en=0, ringing=0, snoozing=0, and all counters=0.
// - Reset also sets the trig edge register to 1, so a trig level already high does not fire after reset.
// - Timebase: ms prescaler 0..MS_CYCLES-1, plus a 24-bit ms down-counter. Both are reloaded on every state entry.
// - Each timed state therefore lasts exactly D*MS_CYCLES clk cycles, where D is its duration in ms.
// - IDLE -> TONE when alarm_trig rises and alarm_en=1. On entry: beep_idx=0, burst_cnt=0, snooze_cnt=0.
// - TONE -> GAP on expiry if beep_idx<BEEPS-1; otherwise TONE -> PAUSE.
// - GAP -> TONE on expiry, with beep_idx+1.
// - PAUSE -> TONE on expiry, with beep_idx=0 and burst_cnt+1.
// - PAUSE -> IDLE instead if burst_cnt+1==MAX_BURSTS (auto-stop).
// - In TONE, rate_out=TONE_A_HZ if beep_idx is even, else TONE_B_HZ.
// - rate_out holds its value for the whole TONE state so the divider limit never changes mid-beep.
// - snooze_btn in TONE/GAP/PAUSE:
//     if snooze_cnt<MAX_SNOOZES -> SNOOZE, snooze_cnt+1;
//     otherwise -> IDLE.
// - SNOOZE -> TONE on expiry, with beep_idx=0 and burst_cnt=0.
// - snooze_btn in SNOOZE is ignored.
// - stop_btn in TONE/GAP/PAUSE/SNOOZE -> IDLE.
// - alarm_trig edges are ignored outside IDLE.
// - alarm_en=0 in any state -> IDLE on the next edge. A rising trig while alarm_en=0 is discarded (not queued).
// - Priority when events coincide: rst > alarm_en=0 > stop_btn > snooze_btn > timer expiry > trig.
// - Outputs update in the same cycle as the state register: tone_en rises on the first cycle in TONE.
// - Latency from trig edge to tone_en=1 is 2 cycles: 1 cycle for edge detect, 1 for the state register.
// - Button pulses in IDLE are ignored. No state carries over from IDLE to the next alarm event.
// TESTING
// (MS_CYCLES=10, BEEP_MS=2, GAP_MS=1, PAUSE_MS=3, SNOOZE_MS=5, BEEPS=4, MAX_BURSTS=2, MAX_SNOOZES=1)
// 1 Trig 0->1 with en=1 -> tone_en=1 two cycles later for 20 cycles with rate=2000; gap 10 cycles;
//   next beep rate=2500; four beeps, then 30 silent cycles, then a repeat.
// 2 No buttons -> after 2 bursts (the second PAUSE expires) state=IDLE, ringing=0, rate_out=1.
// 3 Snooze mid-TONE -> next cycle tone_en=0, snoozing=1 for 50 cycles, then TONE at rate=2000 (beep 0);
//   a second snooze -> IDLE.
// 4 stop_btn and snooze_btn in the same cycle during GAP -> IDLE, snoozing never asserted.
// 5 alarm_en dropped during SNOOZE -> IDLE next cycle; trig edge while en=0 -> no ring;
//   en restored with trig held high -> no ring.
// 6 rst pulse mid-TONE -> next cycle all outputs at reset values; trig held high across reset -> stays IDLE.

Source files
------------

// File: rtl/alarm_tone_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_tone_sequencer
//
// Sequences the alarm buzzer. It drives the rate input of the shared
// programmable square-wave divider (5 MHz base, 23-bit rate in Hz) and gates
// the divider output. When the alarm fires it rings in bursts of BEEPS beeps
// with alternating pitch, separated by GAP_MS of silence, with PAUSE_MS of
// silence after each burst. It handles snooze, stop, alarm disarm and an
// auto-stop after MAX_BURSTS unanswered bursts.
//
// Ports
//   clk         in   1   system clock (5 MHz in the product)
//   rst         in   1   synchronous, active-high reset
//   alarm_en    in   1   alarm armed switch (level)
//   alarm_trig  in   1   alarm time match (level), rising edge detected here
//   snooze_btn  in   1   snooze request, one-cycle pulse (debounced upstream)
//   stop_btn    in   1   stop request, one-cycle pulse (debounced upstream)
//   rate_out    out  23  divider rate: tone in TONE, otherwise 1 (never 0)
//   tone_en     out  1   high only in TONE, gates the divider to the buzzer
//   ringing     out  1   high in TONE, GAP and PAUSE
//   snoozing    out  1   high in SNOOZE
// -----------------------------------------------------------------------------
module alarm_tone_sequencer #(
  parameter int unsigned MS_CYCLES   = 5000,
  parameter int unsigned TONE_A_HZ   = 2000,
  parameter int unsigned TONE_B_HZ   = 2500,
  parameter int unsigned BEEPS       = 4,
  parameter int unsigned BEEP_MS     = 100,
  parameter int unsigned GAP_MS      = 100,
  parameter int unsigned PAUSE_MS    = 600,
  parameter int unsigned SNOOZE_MS   = 300000,
  parameter int unsigned MAX_BURSTS  = 60,
  parameter int unsigned MAX_SNOOZES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alarm_en,
  input  logic        alarm_trig,
  input  logic        snooze_btn,
  input  logic        stop_btn,
  output logic [22:0] rate_out,
  output logic        tone_en,
  output logic        ringing,
  output logic        snoozing
);

  localparam int unsigned PRE_W = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TONE   = 3'd1,
    ST_GAP    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_SNOOZE = 3'd4
  } state_t;

  // Duration in ms loaded into the ms down-counter when a state is entered.
  function automatic logic [23:0] state_dur_ms(input state_t s);
    logic [23:0] d;
    case (s)
      ST_TONE:   d = 24'(BEEP_MS);
      ST_GAP:    d = 24'(GAP_MS);
      ST_PAUSE:  d = 24'(PAUSE_MS);
      ST_SNOOZE: d = 24'(SNOOZE_MS);
      default:   d = 24'd0;
    endcase
    return d;
  endfunction

  // Even-indexed beeps use tone A, odd-indexed beeps use tone B.
  function automatic logic [22:0] beep_rate(input logic [2:0] idx);
    logic [22:0] r;
    if (idx[0]) begin
      r = 23'(TONE_B_HZ);
    end else begin
      r = 23'(TONE_A_HZ);
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [23:0]       ms_q, ms_d;
  logic [2:0]        beep_q, beep_d;
  logic [7:0]        burst_q, burst_d;
  logic [7:0]        snz_q, snz_d;
  logic              trig_q;
  logic              trig_rise_q;
  logic              expired_s;
  logic              pre_wrap_s;
  logic [22:0]       rate_d;
  logic              tone_en_d;
  logic              ringing_d;
  logic              snoozing_d;

  assign pre_wrap_s = (pre_q == PRE_W'(MS_CYCLES - 1));
  // The last cycle of the last ms of a timed state.
  assign expired_s  = pre_wrap_s && (ms_q == 24'd1);

  // Next-state and per-alarm counter logic, priority:
  // disarm > stop > snooze > timer expiry > trigger.
  always_comb begin
    state_d = state_q;
    beep_d  = beep_q;
    burst_d = burst_q;
    snz_d   = snz_q;
    case (state_q)
      ST_IDLE: begin
        if (alarm_en && trig_rise_q) begin
          state_d = ST_TONE;
          beep_d  = 3'd0;
          burst_d = 8'd0;
          snz_d   = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TONE, ST_GAP, ST_PAUSE: begin
        if (!alarm_en || stop_btn) begin
          state_d = ST_IDLE;
        end else if (snooze_btn) begin
          // Once the snooze allowance is used up, snooze acts as stop.
          if (snz_q < 8'(MAX_SNOOZES)) begin
            state_d = ST_SNOOZE;
            snz_d   = snz_q + 8'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (expired_s) begin
          case (state_q)
            ST_TONE: begin
              if (beep_q < 3'(BEEPS - 1)) begin
                state_d = ST_GAP;
              end else begin
                state_d = ST_PAUSE;
              end
            end
            ST_GAP: begin
              state_d = ST_TONE;
              beep_d  = beep_q + 3'd1;
            end
            ST_PAUSE: begin
              if ((burst_q + 8'd1) == 8'(MAX_BURSTS)) begin
                state_d = ST_IDLE;
              end else begin
                state_d = ST_TONE;
                beep_d  = 3'd0;
                burst_d = burst_q + 8'd1;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = state_q;
        end
      end
      ST_SNOOZE: begin
        if (!alarm_en || stop_btn) begin
          state_d = ST_IDLE;
        end else if (expired_s) begin
          state_d = ST_TONE;
          beep_d  = 3'd0;
          burst_d = 8'd0;
        end else begin
          state_d = ST_SNOOZE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Timebase: prescaler plus ms down-counter, both reloaded on every state entry.
  always_comb begin
    pre_d = pre_q;
    ms_d  = ms_q;
    if (state_d != state_q) begin
      pre_d = '0;
      ms_d  = state_dur_ms(state_d);
    end else if (state_q == ST_IDLE) begin
      pre_d = '0;
      ms_d  = 24'd0;
    end else if (pre_wrap_s) begin
      pre_d = '0;
      ms_d  = ms_q - 24'd1;
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // Outputs are decoded from the next state so they change together with the
  // state register; rate only changes on a state change, never mid-beep.
  always_comb begin
    tone_en_d  = (state_d == ST_TONE);
    ringing_d  = (state_d == ST_TONE) || (state_d == ST_GAP) || (state_d == ST_PAUSE);
    snoozing_d = (state_d == ST_SNOOZE);
    if (state_d == ST_TONE) begin
      rate_d = beep_rate(beep_d);
    end else begin
      rate_d = 23'd1;
    end
  end

  // State, counters, trigger edge detect and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pre_q       <= '0;
      ms_q        <= 24'd0;
      beep_q      <= 3'd0;
      burst_q     <= 8'd0;
      snz_q       <= 8'd0;
      // Start high so a trigger level already present does not fire.
      trig_q      <= 1'b1;
      trig_rise_q <= 1'b0;
      rate_out    <= 23'd1;
      tone_en     <= 1'b0;
      ringing     <= 1'b0;
      snoozing    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      ms_q        <= ms_d;
      beep_q      <= beep_d;
      burst_q     <= burst_d;
      snz_q       <= snz_d;
      trig_q      <= alarm_trig;
      // One-cycle pulse; consumed only in IDLE with the alarm armed, never queued.
      trig_rise_q <= alarm_trig && !trig_q;
      rate_out    <= rate_d;
      tone_en     <= tone_en_d;
      ringing     <= ringing_d;
      snoozing    <= snoozing_d;
    end
  end

endmodule

// File: tb/tb_alarm_tone_sequencer.sv
module tb_alarm_tone_sequencer;

  logic        clk;
  logic        rst;
  logic        alarm_en;
  logic        alarm_trig;
  logic        snooze_btn;
  logic        stop_btn;
  logic [22:0] rate_out;
  logic        tone_en;
  logic        ringing;
  logic        snoozing;

  int checks;
  int errors;

  alarm_tone_sequencer #(
    .MS_CYCLES  (10),
    .TONE_A_HZ  (2000),
    .TONE_B_HZ  (2500),
    .BEEPS      (4),
    .BEEP_MS    (2),
    .GAP_MS     (1),
    .PAUSE_MS   (3),
    .SNOOZE_MS  (5),
    .MAX_BURSTS (2),
    .MAX_SNOOZES(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alarm_en  (alarm_en),
    .alarm_trig(alarm_trig),
    .snooze_btn(snooze_btn),
    .stop_btn  (stop_btn),
    .rate_out  (rate_out),
    .tone_en   (tone_en),
    .ringing   (ringing),
    .snoozing  (snoozing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are observed 1 time unit after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Generate a fresh trigger edge and wait until the first TONE cycle.
  task automatic start_alarm();
    alarm_trig = 1'b0;
    step(1);
    alarm_trig = 1'b1;
    step(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; alarm_en = 1'b0; alarm_trig = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    step(3);
    checks++;
    if ({tone_en, ringing, snoozing, rate_out} !== {1'b0, 1'b0, 1'b0, 23'd1}) begin
      errors++;
      $display("FAIL reset: tone_en=%0b ringing=%0b snoozing=%0b rate=%0d, need 0 0 0 1",
               tone_en, ringing, snoozing, rate_out);
    end
    rst = 1'b0;
    step(2);
    checks++;
    if ({tone_en, ringing, snoozing, rate_out} !== {1'b0, 1'b0, 1'b0, 23'd1}) begin
      errors++;
      $display("FAIL reset_idle: tone_en=%0b ringing=%0b snoozing=%0b rate=%0d, need 0 0 0 1",
               tone_en, ringing, snoozing, rate_out);
    end
  endtask

  // Two full bursts with no button press, then auto-stop.
  task automatic test_bursts_autostop();
    int          len   [16];
    logic [25:0] exp_v [16];
    for (int b = 0; b < 2; b++) begin
      len[b*8+0] = 20; exp_v[b*8+0] = {1'b1, 1'b1, 1'b0, 23'd2000};
      len[b*8+1] = 10; exp_v[b*8+1] = {1'b0, 1'b1, 1'b0, 23'd1};
      len[b*8+2] = 20; exp_v[b*8+2] = {1'b1, 1'b1, 1'b0, 23'd2500};
      len[b*8+3] = 10; exp_v[b*8+3] = {1'b0, 1'b1, 1'b0, 23'd1};
      len[b*8+4] = 20; exp_v[b*8+4] = {1'b1, 1'b1, 1'b0, 23'd2000};
      len[b*8+5] = 10; exp_v[b*8+5] = {1'b0, 1'b1, 1'b0, 23'd1};
      len[b*8+6] = 20; exp_v[b*8+6] = {1'b1, 1'b1, 1'b0, 23'd2500};
      len[b*8+7] = 30; exp_v[b*8+7] = {1'b0, 1'b1, 1'b0, 23'd1};
    end
    alarm_en = 1'b1;
    alarm_trig = 1'b0;
    step(2);
    alarm_trig = 1'b1;
    step(1);
    checks++;
    if (tone_en !== 1'b0 || ringing !== 1'b0) begin
      errors++;
      $display("FAIL trig_latency1: tone_en=%0b ringing=%0b, need 0 0", tone_en, ringing);
    end
    step(1);
    for (int p = 0; p < 16; p++) begin
      for (int c = 0; c < len[p]; c++) begin
        checks++;
        if ({tone_en, ringing, snoozing, rate_out} !== exp_v[p]) begin
          errors++;
          $display("FAIL burst_phase%0d_cyc%0d: tone_en=%0b ringing=%0b snoozing=%0b rate=%0d, need %0b %0b %0b %0d",
                   p, c, tone_en, ringing, snoozing, rate_out,
                   exp_v[p][25], exp_v[p][24], exp_v[p][23], exp_v[p][22:0]);
        end
        step(1);
      end
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({tone_en, ringing, snoozing, rate_out} !== {1'b0, 1'b0, 1'b0, 23'd1}) begin
        errors++;
        $display("FAIL autostop_idle%0d: tone_en=%0b ringing=%0b snoozing=%0b rate=%0d, need 0 0 0 1",
                 c, tone_en, ringing, snoozing, rate_out);
      end
      step(1);
    end
  endtask

  task automatic test_snooze();
    start_alarm();
    step(5);
    snooze_btn = 1'b1;
    step(1);
    snooze_btn = 1'b0;
    for (int c = 0; c < 50; c++) begin
      checks++;
      if ({tone_en, ringing, snoozing, rate_out} !== {1'b0, 1'b0, 1'b1, 23'd1}) begin
        errors++;
        $display("FAIL snooze_cyc%0d: tone_en=%0b ringing=%0b snoozing=%0b rate=%0d, need 0 0 1 1",
                 c, tone_en, ringing, snoozing, rate_out);
      end
      step(1);
    end
    checks++;
    if ({tone_en, ringing, snoozing, rate_out} !== {1'b1, 1'b1, 1'b0, 23'd2000}) begin
      errors++;
      $display("FAIL snooze_resume: tone_en=%0b ringing=%0b snoozing=%0b rate=%0d, need 1 1 0 2000",
               tone_en, ringing, snoozing, rate_out);
    end
    snooze_btn = 1'b1;
    step(1);
    snooze_btn = 1'b0;
    checks++;
    if ({tone_en, ringing, snoozing, rate_out} !== {1'b0, 1'b0, 1'b0, 23'd1}) begin
      errors++;
      $display("FAIL snooze_limit_stop: tone_en=%0b ringing=%0b snoozing=%0b rate=%0d, need 0 0 0 1",
               tone_en, ringing, snoozing, rate_out);
    end
  endtask

  task automatic test_stop_and_snooze();
    start_alarm();
    step(20);
    checks++;
    if ({tone_en, ringing} !== 2'b01) begin
      errors++;
      $display("FAIL gap_reached: tone_en=%0b ringing=%0b, need 0 1", tone_en, ringing);
    end
    stop_btn = 1'b1;
    snooze_btn = 1'b1;
    step(1);
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({tone_en, ringing, snoozing, rate_out} !== {1'b0, 1'b0, 1'b0, 23'd1}) begin
        errors++;
        $display("FAIL stop_over_snooze%0d: tone_en=%0b ringing=%0b snoozing=%0b rate=%0d, need 0 0 0 1",
                 c, tone_en, ringing, snoozing, rate_out);
      end
      step(1);
    end
  endtask

  task automatic test_disarm();
    start_alarm();
    snooze_btn = 1'b1;
    step(1);
    snooze_btn = 1'b0;
    step(3);
    checks++;
    if (snoozing !== 1'b1) begin
      errors++;
      $display("FAIL disarm_in_snooze: snoozing=%0b, need 1", snoozing);
    end
    alarm_en = 1'b0;
    step(1);
    checks++;
    if ({tone_en, ringing, snoozing, rate_out} !== {1'b0, 1'b0, 1'b0, 23'd1}) begin
      errors++;
      $display("FAIL disarm_idle: tone_en=%0b ringing=%0b snoozing=%0b rate=%0d, need 0 0 0 1",
               tone_en, ringing, snoozing, rate_out);
    end
    alarm_trig = 1'b0;
    step(1);
    alarm_trig = 1'b1;
    step(4);
    checks++;
    if ({tone_en, ringing, snoozing} !== 3'b000) begin
      errors++;
      $display("FAIL trig_while_disarmed: tone_en=%0b ringing=%0b snoozing=%0b, need 0 0 0",
               tone_en, ringing, snoozing);
    end
    alarm_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1);
      checks++;
      if ({tone_en, ringing, snoozing} !== 3'b000) begin
        errors++;
        $display("FAIL rearm_no_ring%0d: tone_en=%0b ringing=%0b snoozing=%0b, need 0 0 0",
                 c, tone_en, ringing, snoozing);
      end
    end
  endtask

  task automatic test_reset_mid_tone();
    alarm_en = 1'b1;
    start_alarm();
    step(5);
    checks++;
    if (tone_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_tone: tone_en=%0b, need 1", tone_en);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if ({tone_en, ringing, snoozing, rate_out} !== {1'b0, 1'b0, 1'b0, 23'd1}) begin
      errors++;
      $display("FAIL reset_mid_tone: tone_en=%0b ringing=%0b snoozing=%0b rate=%0d, need 0 0 0 1",
               tone_en, ringing, snoozing, rate_out);
    end
    for (int c = 0; c < 5; c++) begin
      step(1);
      checks++;
      if ({tone_en, ringing, snoozing, rate_out} !== {1'b0, 1'b0, 1'b0, 23'd1}) begin
        errors++;
        $display("FAIL trig_held_after_reset%0d: tone_en=%0b ringing=%0b snoozing=%0b rate=%0d, need 0 0 0 1",
                 c, tone_en, ringing, snoozing, rate_out);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bursts_autostop();
    test_snooze();
    test_stop_and_snooze();
    test_disarm();
    test_reset_mid_tone();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
